// File: rtl/adaptive_filter_pkg.sv
// Shared types and constants for adaptive_filter and its inverse.
// The sample format is signed two's complement Q(WORDLENGTH-FRACTIONAL_LENGTH).FRACTIONAL_LENGTH.
package adaptive_filter_pkg;

    localparam int unsigned WORDLENGTH        = 14;
    localparam int unsigned FRACTIONAL_LENGTH = 6;

    typedef logic signed [WORDLENGTH-1:0] sample_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Forward-filter mode encodings, as seen on ctrl and mode.
    localparam logic MODE_INTEGRATOR     = 1'b1;
    localparam logic MODE_DIFFERENTIATOR = 1'b0;

endpackage

// File: rtl/adaptive_filter_inverse.sv
// Streaming inverse of adaptive_filter: differentiates an integrated stream or accumulates a
// differentiated one, frame by frame, with a single registered output stage.
module adaptive_filter_inverse #(
    parameter int unsigned WORDLENGTH        = adaptive_filter_pkg::WORDLENGTH,
    parameter int unsigned FRACTIONAL_LENGTH = adaptive_filter_pkg::FRACTIONAL_LENGTH
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         ctrl,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic signed [WORDLENGTH-1:0] s_tdata,
    input  logic                         s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic signed [WORDLENGTH-1:0] m_tdata,
    output logic                         m_tlast,
    output logic                         mode
);
    import adaptive_filter_pkg::*;

    // The binary point is only a labelling convention; arithmetic is integer-exact.
    if (FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_bad_format
        $error("FRACTIONAL_LENGTH must be smaller than WORDLENGTH");
    end

    state_t                state;
    logic [WORDLENGTH-1:0] h;

    logic                  in_beat;
    logic                  out_beat;
    logic                  cur_mode;
    logic [WORDLENGTH-1:0] hist;
    logic [WORDLENGTH-1:0] result;
    logic [WORDLENGTH-1:0] h_next;

    assign s_tready = !srst && (!m_tvalid || m_tready);
    assign in_beat  = s_tvalid && s_tready;
    assign out_beat = m_tvalid && m_tready;

    // The first beat of a frame takes its mode from ctrl and sees an empty history.
    always_comb begin
        cur_mode = mode;
        hist     = h;
        if (state == IDLE) begin
            cur_mode = ctrl;
            hist     = '0;
        end
        if (cur_mode == MODE_INTEGRATOR) begin
            result = s_tdata - hist;
            h_next = s_tdata;
        end else begin
            result = hist + s_tdata;
            h_next = result;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state    <= IDLE;
            h        <= '0;
            mode     <= MODE_DIFFERENTIATOR;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            if (in_beat) begin
                m_tvalid <= 1'b1;
                m_tdata  <= result;
                m_tlast  <= s_tlast;
                if (state == IDLE) begin
                    mode <= ctrl;
                end
                if (s_tlast) begin
                    state <= IDLE;
                    h     <= '0;
                end else begin
                    state <= RUN;
                    h     <= h_next;
                end
            end else if (out_beat) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adaptive_filter_inverse.sv
// Scoreboard bench for adaptive_filter_inverse: directed frames plus a randomized loop-back
// through a behavioural forward filter whose original samples are the expected output.
module tb_adaptive_filter_inverse;
    import adaptive_filter_pkg::*;

    localparam int W = WORDLENGTH;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic                clk;
    logic                srst;
    logic                ctrl;
    logic                s_tvalid;
    logic                s_tready;
    logic signed [W-1:0] s_tdata;
    logic                s_tlast;
    logic                m_tvalid;
    logic                m_tready;
    logic signed [W-1:0] m_tdata;
    logic                m_tlast;
    logic                mode;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rdy_random = 0;
    bit   rdy_force = 1;

    adaptive_filter_inverse #(
        .WORDLENGTH       (WORDLENGTH),
        .FRACTIONAL_LENGTH(FRACTIONAL_LENGTH)
    ) dut (
        .clk     (clk),
        .srst    (srst),
        .ctrl    (ctrl),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tdata (s_tdata),
        .s_tlast (s_tlast),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata (m_tdata),
        .m_tlast (m_tlast),
        .mode    (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act,
                     $signed(exp), exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every output beat pops one expected sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected no output", m_tdata);
                end else begin
                    e = sb.pop_front();
                    check("m_tdata", m_tdata, e.data);
                    check1("m_tlast", m_tlast, e.last);
                end
            end
        end
    end

    // Downstream ready, applied just after each rising edge.
    initial begin
        logic [31:0] r;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            r = $urandom;
            m_tready = rdy_random ? (r[1:0] != 2'b00) : rdy_force;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input bit last, input bit c,
                        input logic [W-1:0] expd);
        exp_t e;
        bit   hs;
        int   n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        ctrl     = c;
        hs = 0;
        n  = 0;
        while (!hs && n < 1000) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_tready=0 for 1000 cycles expected acceptance");
        end else begin
            e.data = expd;
            e.last = last;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic drain();
        int n;
        rdy_random = 0;
        rdy_force  = 1;
        n = 0;
        while ((sb.size() != 0 || m_tvalid) && n < 2000) begin
            sync();
            n++;
        end
        checks++;
        if (sb.size() != 0 || m_tvalid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending outputs expected 0", sb.size());
        end
    endtask

    task automatic loopback(input bit m, input int total);
        logic [31:0]  r;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] prev;
        int           remaining;
        int           len;
        remaining  = total;
        rdy_random = 1;
        while (remaining > 0) begin
            len = $urandom_range(1, 20);
            if (len > remaining) len = remaining;
            prev = '0;
            for (int i = 0; i < len; i++) begin
                r = $urandom;
                x = r[W-1:0];
                // Forward filter: running sum (integrator) or first difference.
                if (m == MODE_INTEGRATOR) begin
                    y    = prev + x;
                    prev = y;
                end else begin
                    y    = x - prev;
                    prev = x;
                end
                // ctrl after the first beat is deliberately scrambled; it must be ignored.
                send(y, i == len - 1, (i == 0) ? m : bit'($urandom_range(0, 1)), x);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            remaining -= len;
        end
        drain();
    endtask

    initial begin
        int c0;
        int n;
        srst     = 1'b1;
        ctrl     = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        check1("s_tready_in_reset", s_tready, 1'b0);
        sync();
        srst = 1'b0;
        @(negedge clk);
        check1("reset_m_tvalid", m_tvalid, 1'b0);
        check("reset_m_tdata", m_tdata, '0);
        check1("reset_m_tlast", m_tlast, 1'b0);
        check1("reset_mode", mode, 1'b0);
        check1("ready_after_reset", s_tready, 1'b1);
        sync();

        // Integrator inverse, back-to-back, 1-cycle latency.
        c0 = cyc;
        send(14'd64, 0, 1, 14'd64);
        send(14'd128, 0, 1, 14'd64);
        send(14'd192, 0, 1, 14'd64);
        send(14'd256, 1, 1, 14'd64);
        check("throughput_cycles", W'(cyc - c0), W'(4));
        @(negedge clk);
        check1("latency_valid", m_tvalid, 1'b1);
        check1("latency_last", m_tlast, 1'b1);
        check("latency_data", m_tdata, 14'd64);
        sync();
        drain();

        // Differentiator inverse; next frame must start with cleared history.
        send(14'd64, 0, 0, 14'd64);
        send(14'd64, 0, 0, 14'd128);
        send(14'd64, 1, 0, 14'd192);
        send(14'd64, 1, 0, 14'd64);
        drain();

        // Wrap-around.
        send(14'd8191, 0, 0, 14'd8191);
        send(14'd64, 1, 0, 14'h203F);
        send(14'h2000, 0, 1, 14'h2000);
        send(14'd8191, 1, 1, 14'h3FFF);
        drain();

        // Backpressure: first output held while downstream stalls.
        rdy_force = 0;
        fork
            begin
                send(14'd10, 0, 1, 14'd10);
                send(14'd30, 0, 1, 14'd20);
                send(14'd60, 1, 1, 14'd30);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (m_tvalid !== 1'b1 && n < 50);
                for (int i = 0; i < 3; i++) begin
                    check1("bp_s_tready", s_tready, 1'b0);
                    check1("bp_m_tvalid", m_tvalid, 1'b1);
                    check("bp_m_tdata", m_tdata, 14'd10);
                    if (i < 2) @(negedge clk);
                end
                rdy_force = 1;
            end
        join
        drain();

        // ctrl changes mid-frame are ignored.
        send(14'd100, 0, 1, 14'd100);
        @(negedge clk);
        check1("mode_latched_1", mode, 1'b1);
        sync();
        send(14'd150, 0, 0, 14'd50);
        send(14'd175, 1, 0, 14'd25);
        send(14'd1, 0, 0, 14'd1);
        @(negedge clk);
        check1("mode_latched_0", mode, 1'b0);
        sync();
        send(14'd2, 1, 1, 14'd3);
        drain();

        // Reset mid-frame discards the frame.
        send(14'd5, 0, 0, 14'd5);
        send(14'd5, 0, 0, 14'd10);
        srst = 1'b1;
        @(negedge clk);
        check1("midframe_s_tready", s_tready, 1'b0);
        sync();
        srst = 1'b0;
        @(negedge clk);
        check1("midframe_m_tvalid", m_tvalid, 1'b0);
        sync();
        send(14'd7, 0, 0, 14'd7);
        send(14'd7, 1, 0, 14'd14);
        drain();

        // Randomized loop-back through the forward filter, both modes.
        loopback(MODE_INTEGRATOR, 128);
        loopback(MODE_DIFFERENTIATOR, 128);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adaptive_filter_inverse.md
Name: adaptive_filter_inverse

Overview:
- Streaming inverse of the adaptive integrator/differentiator filter. It reconstructs the original sample stream from the filtered stream, for loop-back self-checking and for the receive path.
- Forward integrator (ctrl=1) y[n]=y[n-1]+x[n] is inverted by a differentiator: x[n]=y[n]-y[n-1].
- Forward differentiator (ctrl=0) y[n]=x[n]-x[n-1] is inverted by an accumulator: x[n]=x[n-1]+y[n].
- Sits directly after adaptive_filter. Samples are signed fixed point with valid/ready handshakes and frame delimiting.

Parameters:
- WORDLENGTH, 14, total sample width in bits, signed two's complement.
- FRACTIONAL_LENGTH, 6, fractional bits. Informational only, since the arithmetic is integer-exact.

Ports:
- clk  in  1  clock, rising edge.
- srst  in  1  synchronous reset, active-high.
- ctrl  in  1  forward-filter mode to invert: 1 = integrator (block differentiates), 0 = differentiator (block accumulates).
- s_tvalid  in  1  input sample valid.
- s_tready  out  1  block accepts a sample.
- s_tdata  in  WORDLENGTH  filtered sample, signed Q(WORDLENGTH-FRACTIONAL_LENGTH).FRACTIONAL_LENGTH.
- s_tlast  in  1  last sample of frame.
- m_tvalid  out  1  reconstructed sample valid.
- m_tready  in  1  downstream accepts.
- m_tdata  out  WORDLENGTH  reconstructed sample, same format as s_tdata.
- m_tlast  out  1  last sample of frame, aligned with m_tdata.
- mode  out  1  mode latched for the current frame. Valid while state is RUN.

Behaviour:
- Reset (srst=1 at a clk edge): state=IDLE, history register h=0, mode=0, m_tvalid=0, m_tdata=0, m_tlast=0. s_tready is 0 during the reset cycle. srst overrides everything, including a reset mid-frame; any sample in flight is discarded.
- Handshake:
  - Input beat when s_tvalid && s_tready. Output beat when m_tvalid && m_tready.
  - s_tready = !m_tvalid || m_tready (single output register, no combinational path s_tdata->m_tdata).
  - m_tdata and m_tlast stay stable while m_tvalid && !m_tready. m_tvalid is never retracted without a beat.
- Latency: 1 cycle. An input beat at edge k gives m_tvalid=1 with its result after edge k. Full throughput of 1 sample/clk when m_tready=1.
- FSM:
  - IDLE: waiting for the first beat of a frame; h=0. On an input beat: latch mode<=ctrl, compute the output with h=0, update h. Go to RUN, or stay in IDLE if s_tlast=1 (single-sample frame).
  - RUN: ctrl is ignored and mode is held. Each input beat computes the output and updates h. A beat with s_tlast=1 returns the FSM to IDLE and forces h=0 for the next frame.
- Arithmetic, with d = s_tdata:
  - mode=1: out = d - h, then h <= d.
  - mode=0: out = h + d, then h <= out.
  - Both use WORDLENGTH-bit modular (wrap-around) arithmetic, no saturation, so the inverse is bit-exact with a wrapping forward filter.
  - The first sample of a frame uses h=0, so out = d in both modes.
- m_tlast <= s_tlast on each input beat.
- Idle input (s_tvalid=0): state and h are unchanged.
- Simultaneous output beat and input beat in the same cycle: the output register reloads, m_tvalid stays 1.

Decomposition:
- Package adaptive_filter_pkg holds:
  - WORDLENGTH and FRACTIONAL_LENGTH defaults;
  - typedef sample_t (signed [WORDLENGTH-1:0]);
  - enum state_t {IDLE, RUN};
  - mode encodings MODE_INTEGRATOR=1, MODE_DIFFERENTIATOR=0. These are shared with adaptive_filter and its bench.
- No sub-module needed. The output register is inline. If a skid buffer is added later, it becomes a separate axis_skid_reg.

Test Plan:
- ctrl=1, frame [64,128,192,256] (1.0,2.0,3.0,4.0), tlast on the 4th sample, m_tready=1 -> outputs 64,64,64,64; m_tlast on the 4th only; 1-cycle latency, back-to-back.
- ctrl=0, frame [64,64,64] -> outputs 64,128,192; next frame [64] -> 64, confirming history is cleared by tlast.
- Wrap: ctrl=0, frame [8191,64] -> 8191, -8129 (0x203F). ctrl=1, frame [-8192,8191] -> -8192, -1.
- Backpressure: ctrl=1 stream [10,30,60], m_tready low for 3 cycles after the first output -> s_tready=0 and m_tdata held at 10 throughout; then 20 and 30 follow with no loss or duplication.
- ctrl toggled 1->0 mid-frame [100,150,175] -> mode stays 1, outputs 100,50,25. The next frame uses ctrl=0.
- srst asserted for 1 cycle after the 2nd beat of a ctrl=0 frame [5,5,5] -> m_tvalid=0 next cycle, state IDLE. Following frame [7,7] -> 7,14.
- Loop-back: adaptive_filter followed by this block, with the same ctrl, on 128 random samples -> output equals input bit-exact in both modes.
